// File: rtl/oneapi_gasket_pkg.sv
// Shared types and helpers for the AXI4-Stream to Avalon-ST receive gasket.
// Holds the frame-sync state type, the SOF tuser bit index and a width-check helper.
package oneapi_gasket_pkg;

  typedef enum logic [0:0] {WAIT_SOF, PASS} gasket_state_e;

  localparam int unsigned SOF_TUSER_BIT = 0;

  // A bus is consistent when its width is exactly pixels times the per-pixel stride.
  function automatic bit widths_ok(input int unsigned total, input int unsigned pixels,
                                   input int unsigned stride);
    return total == pixels * stride;
  endfunction

endpackage

// File: rtl/oneapi_gasket_skid_buffer.sv
// Generic 2-entry registered FIFO with valid/ready on both sides.
// The input ready comes from a register, so there is no combinational ready path.
module oneapi_gasket_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q;
  logic             push, pop;

  assign push        = in_valid_i && ready_q;
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign in_ready_o  = ready_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together: count is unchanged, order is preserved.
        if (count_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/oneapi_axi_to_avalon_gasket.sv
// Receive gasket: AXI4-Stream video (tuser[0] = SOF, tlast = EOL) to Avalon-ST for a oneAPI
// kernel, with channel repacking, a 2-entry skid buffer and a frame-sync FSM.
module oneapi_axi_to_avalon_gasket
  import oneapi_gasket_pkg::*;
#(
  parameter int unsigned PARALLEL_PIXELS      = 1,
  parameter int unsigned CHANNELS             = 3,
  parameter int unsigned BITS_PER_CHANNEL_AXI = 8,
  parameter int unsigned BITS_PER_PIXEL_AXI   = 24,
  parameter int unsigned BITS_AXI             = 24,
  parameter int unsigned BITS_PER_CHANNEL_AV  = 8,
  parameter int unsigned BITS_PER_PIXEL_AV    = 24,
  parameter int unsigned BITS_AV              = 24,
  parameter int unsigned EMPTY_BITS           = 2,
  parameter int unsigned TUSER_BITS           = 3,
  parameter int unsigned ERR_CNT_BITS         = 8
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset,
  input  logic                    axs_tvalid,
  output logic                    axs_tready,
  input  logic [BITS_AXI-1:0]     axs_tdata,
  input  logic                    axs_tlast,
  input  logic [TUSER_BITS-1:0]   axs_tuser,
  output logic                    aso_valid,
  input  logic                    aso_ready,
  output logic [BITS_AV-1:0]      aso_data,
  output logic                    aso_startofpacket,
  output logic                    aso_endofpacket,
  output logic [EMPTY_BITS-1:0]   aso_empty,
  output logic                    in_sync,
  output logic [ERR_CNT_BITS-1:0] resync_err_count
);

  if (!widths_ok(BITS_AXI, PARALLEL_PIXELS, BITS_PER_PIXEL_AXI) ||
      !widths_ok(BITS_AV, PARALLEL_PIXELS, BITS_PER_PIXEL_AV) ||
      (BITS_PER_CHANNEL_AV < BITS_PER_CHANNEL_AXI)) begin : g_bad_params
    $error("oneapi_axi_to_avalon_gasket: inconsistent width parameters");
  end

  gasket_state_e           state_q, state_d;
  logic                    mid_line_q, mid_line_d;
  logic [ERR_CNT_BITS-1:0] err_q, err_d;
  logic [BITS_AV-1:0]      repacked;
  logic                    sof, accept, store;
  logic [BITS_AV+1:0]      buf_out;
  logic                    unused_inputs;

  assign sof    = axs_tuser[SOF_TUSER_BIT];
  assign accept = axs_tvalid && axs_tready;
  assign store  = (state_q == PASS) || sof;

  // AXI padding is dropped; Avalon channel MSBs and padding are zero.
  always_comb begin
    repacked = '0;
    for (int p = 0; p < PARALLEL_PIXELS; p++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        repacked[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV] =
          BITS_PER_CHANNEL_AV'(axs_tdata[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +:
                                         BITS_PER_CHANNEL_AXI]);
      end
    end
  end

  assign unused_inputs = ^{axs_tuser, axs_tdata};

  oneapi_gasket_skid_buffer #(
    .WIDTH (BITS_AV + 2)
  ) u_skid (
    .clk_i       (csi_clk),
    .rst_i       (rsi_reset),
    .in_valid_i  (axs_tvalid && store),
    .in_ready_o  (axs_tready),
    .in_data_i   ({sof, axs_tlast, repacked}),
    .out_valid_o (aso_valid),
    .out_ready_i (aso_ready),
    .out_data_o  (buf_out)
  );

  assign aso_startofpacket = buf_out[BITS_AV+1];
  assign aso_endofpacket   = buf_out[BITS_AV];
  assign aso_data          = buf_out[BITS_AV-1:0];
  assign aso_empty         = '0;
  assign in_sync           = (state_q == PASS);
  assign resync_err_count  = err_q;

  always_comb begin
    state_d    = state_q;
    mid_line_d = mid_line_q;
    err_d      = err_q;
    if (accept) begin
      unique case (state_q)
        WAIT_SOF: begin
          if (sof) begin
            state_d    = PASS;
            mid_line_d = !axs_tlast;
          end
        end
        PASS: begin
          mid_line_d = !axs_tlast;
          if (sof && mid_line_q && (err_q != '1)) err_d = err_q + 1'b1;
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q    <= WAIT_SOF;
      mid_line_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      mid_line_q <= mid_line_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_oneapi_axi_to_avalon_gasket.sv
// Self-checking bench for oneapi_axi_to_avalon_gasket: vector table plus hand-written
// sequences, with an output scoreboard fed when beats are accepted.
module tb_oneapi_axi_to_avalon_gasket;

  logic        csi_clk = 1'b0;
  logic        rsi_reset;
  logic        axs_tvalid, axs_tready, axs_tlast;
  logic [23:0] axs_tdata;
  logic [2:0]  axs_tuser;
  logic        aso_valid, aso_ready, aso_startofpacket, aso_endofpacket;
  logic [23:0] aso_data;
  logic [1:0]  aso_empty;
  logic        in_sync;
  logic [7:0]  resync_err_count;

  // Second instance with padded AXI pixels and 10-bit Avalon channels.
  logic        tvalid2, tready2, tlast2, valid2, sop2, eop2, sync2;
  logic [31:0] tdata2;
  logic [2:0]  tuser2;
  logic [29:0] data2;
  logic [1:0]  empty2;
  logic [7:0]  err2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic sop; logic eop; logic [23:0] data;} exp_t;
  exp_t sb[$];

  typedef struct {
    logic sof; logic last; logic [23:0] data;
    bit keep; bit exp_sop; bit exp_eop; bit exp_sync;
  } vec_t;
  vec_t vec[11];

  always #5 csi_clk = ~csi_clk;

  oneapi_axi_to_avalon_gasket u_dut (
    .csi_clk           (csi_clk),
    .rsi_reset         (rsi_reset),
    .axs_tvalid        (axs_tvalid),
    .axs_tready        (axs_tready),
    .axs_tdata         (axs_tdata),
    .axs_tlast         (axs_tlast),
    .axs_tuser         (axs_tuser),
    .aso_valid         (aso_valid),
    .aso_ready         (aso_ready),
    .aso_data          (aso_data),
    .aso_startofpacket (aso_startofpacket),
    .aso_endofpacket   (aso_endofpacket),
    .aso_empty         (aso_empty),
    .in_sync           (in_sync),
    .resync_err_count  (resync_err_count)
  );

  oneapi_axi_to_avalon_gasket #(
    .BITS_PER_PIXEL_AXI  (32),
    .BITS_AXI            (32),
    .BITS_PER_CHANNEL_AV (10),
    .BITS_PER_PIXEL_AV   (30),
    .BITS_AV             (30)
  ) u_dut2 (
    .csi_clk           (csi_clk),
    .rsi_reset         (rsi_reset),
    .axs_tvalid        (tvalid2),
    .axs_tready        (tready2),
    .axs_tdata         (tdata2),
    .axs_tlast         (tlast2),
    .axs_tuser         (tuser2),
    .aso_valid         (valid2),
    .aso_ready         (1'b1),
    .aso_data          (data2),
    .aso_startofpacket (sop2),
    .aso_endofpacket   (eop2),
    .aso_empty         (empty2),
    .in_sync           (sync2),
    .resync_err_count  (err2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pop at the output must match the oldest stored beat.
  always @(negedge csi_clk) begin
    if (!rsi_reset && aso_valid && aso_ready) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected no beat", aso_data);
      end else begin
        e = sb.pop_front();
        check("sb_beat", {aso_startofpacket, aso_endofpacket, aso_data},
              {e.sop, e.eop, e.data});
      end
    end
  end

  // Drive one beat until accepted; push an expectation when it should be stored.
  task automatic send_beat(input logic sof, input logic last, input logic [23:0] data,
                           input bit keep);
    bit got = 0;
    axs_tvalid = 1'b1;
    axs_tuser  = {2'b00, sof};
    axs_tlast  = last;
    axs_tdata  = data;
    for (int i = 0; i < 64; i++) begin
      @(negedge csi_clk);
      if (axs_tready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("send_timeout", 64'd0, 64'd1);
    end else if (keep) begin
      sb.push_back('{sop: sof, eop: last, data: data});
    end
    @(posedge csi_clk);
    #1;
    axs_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge csi_clk);
      #2;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec[0]  = '{1'b0, 1'b0, 24'h111111, 0, 0, 0, 0};
    vec[1]  = '{1'b0, 1'b1, 24'h222222, 0, 0, 0, 0};
    vec[2]  = '{1'b0, 1'b0, 24'h333333, 0, 0, 0, 0};
    vec[3]  = '{1'b1, 1'b0, 24'hA00001, 1, 1, 0, 1};
    vec[4]  = '{1'b0, 1'b0, 24'hA00002, 1, 0, 0, 1};
    vec[5]  = '{1'b0, 1'b0, 24'hA00003, 1, 0, 0, 1};
    vec[6]  = '{1'b0, 1'b1, 24'hA00004, 1, 0, 1, 1};
    vec[7]  = '{1'b0, 1'b0, 24'hB00001, 1, 0, 0, 1};
    vec[8]  = '{1'b0, 1'b1, 24'hB00002, 1, 0, 1, 1};
    vec[9]  = '{1'b1, 1'b1, 24'hC0FFEE, 1, 1, 1, 1};
    vec[10] = '{1'b1, 1'b1, 24'h123456, 1, 1, 1, 1};

    rsi_reset  = 1'b1;
    axs_tvalid = 1'b0;
    axs_tlast  = 1'b0;
    axs_tuser  = '0;
    axs_tdata  = '0;
    aso_ready  = 1'b1;
    tvalid2    = 1'b0;
    tdata2     = '0;
    tlast2     = 1'b0;
    tuser2     = '0;

    // Reset state
    repeat (3) @(posedge csi_clk);
    #1;
    check("rst_valid", aso_valid, 0);
    check("rst_tready", axs_tready, 0);
    check("rst_sync", in_sync, 0);
    check("rst_err", resync_err_count, 0);
    check("rst_empty", aso_empty, 0);
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    @(posedge csi_clk);
    #1;
    check("post_rst_tready", axs_tready, 1);

    // Table: dropped pre-SOF beats, a 4-beat line, a plain line, one-pixel lines.
    for (int i = 0; i < 11; i++) begin
      axs_tvalid = 1'b1;
      axs_tuser  = {2'b00, vec[i].sof};
      axs_tlast  = vec[i].last;
      axs_tdata  = vec[i].data;
      @(negedge csi_clk);
      check("vec_tready", axs_tready, 1);
      if (vec[i].keep)
        sb.push_back('{sop: vec[i].exp_sop, eop: vec[i].exp_eop, data: vec[i].data});
      @(posedge csi_clk);
      #1;
      check("vec_valid", aso_valid, vec[i].keep);
      check("vec_sync", in_sync, vec[i].exp_sync);
    end
    axs_tvalid = 1'b0;
    wait_drain("vec_drain");
    check("vec_err", resync_err_count, 0);

    // Backpressure: only two beats fit, ready drops after the second accept.
    begin : backpressure
      int n_acc = 0;
      aso_ready  = 1'b0;
      axs_tvalid = 1'b1;
      axs_tuser  = '0;
      axs_tlast  = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
        axs_tdata = 24'hD00000 + 24'(n_acc);
        @(negedge csi_clk);
        if (n_acc >= 2) check("bp_tready_low", axs_tready, 0);
        if (axs_tready) begin
          sb.push_back('{sop: 1'b0, eop: 1'b1, data: axs_tdata});
          n_acc++;
        end
        @(posedge csi_clk);
        #1;
      end
      check("bp_accepts", 64'(n_acc), 64'd2);
      check("bp_valid", aso_valid, 1);
      axs_tvalid = 1'b0;
      aso_ready  = 1'b1;
      wait_drain("bp_drain");
    end

    // Padded AXI pixel into 10-bit Avalon channels
    tvalid2 = 1'b1;
    tdata2  = 32'hFF302010;
    tuser2  = 3'b001;
    tlast2  = 1'b1;
    begin : repack
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge csi_clk);
        if (tready2) begin
          got = 1;
          break;
        end
      end
      check("rp_accept", got, 1);
      @(posedge csi_clk);
      #1;
      tvalid2 = 1'b0;
      check("rp_valid", valid2, 1);
      check("rp_data", data2, {10'h030, 10'h020, 10'h010});
      check("rp_sop_eop", {sop2, eop2}, 2'b11);
    end

    // Repeated mid-line SOF: error counter saturates, beats carry sop.
    send_beat(1'b1, 1'b0, 24'hE00000, 1);
    for (int k = 1; k <= 300; k++) begin
      send_beat(1'b1, 1'b0, 24'hE00000 + 24'(k), 1);
      send_beat(1'b0, 1'b0, 24'hF00000 + 24'(k), 1);
      if (k == 10) check("sat_err_10", resync_err_count, 10);
      if (k == 255) check("sat_err_255", resync_err_count, 255);
    end
    send_beat(1'b0, 1'b1, 24'hEEEEEE, 1);
    wait_drain("sat_drain");
    check("sat_err_final", resync_err_count, 255);
    check("sat_sync", in_sync, 1);

    // Async reset with two beats buffered, then resync on the next SOF only.
    aso_ready = 1'b0;
    send_beat(1'b1, 1'b0, 24'h5A0001, 1);
    send_beat(1'b0, 1'b0, 24'h5A0002, 1);
    check("rr_full_tready", axs_tready, 0);
    check("rr_full_valid", aso_valid, 1);
    #2;
    rsi_reset = 1'b1;
    #1;
    check("rr_valid", aso_valid, 0);
    check("rr_sync", in_sync, 0);
    check("rr_err", resync_err_count, 0);
    sb.delete();
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    aso_ready = 1'b1;
    @(posedge csi_clk);
    #1;
    send_beat(1'b0, 1'b0, 24'h600001, 0);
    check("rr_drop1", aso_valid, 0);
    send_beat(1'b0, 1'b1, 24'h600002, 0);
    check("rr_drop2", aso_valid, 0);
    check("rr_still_unsynced", in_sync, 0);
    send_beat(1'b1, 1'b1, 24'h700001, 1);
    check("rr_resync_valid", aso_valid, 1);
    check("rr_resync", in_sync, 1);
    wait_drain("rr_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
